// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the instruction cache.
// No logic of its own; all helpers are pure combinational functions.
// Field widths default to a 16-line, 4-word-per-line cache of 32-bit words.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    localparam int LINES_DEF  = 16;
    localparam int WORDS_DEF  = 4;
    localparam int WORD_BITS  = $clog2(WORDS_DEF);
    localparam int INDEX_BITS = $clog2(LINES_DEF);
    localparam int TAG_BITS   = 32 - 2 - WORD_BITS - INDEX_BITS;

    // Word-within-line field: the bits just above the byte offset.
    function automatic logic [31:0] pc_word(input logic [31:0] pc, input int wb);
        return (pc >> 2) & ((32'd1 << wb) - 32'd1);
    endfunction

    // Line index field: the bits above the word field.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int wb, input int ib);
        return (pc >> (2 + wb)) & ((32'd1 << ib) - 32'd1);
    endfunction

    // Tag field: everything above the index.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int wb, input int ib);
        return pc >> (2 + wb + ib);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache bundled together.
// No latency of its own; pure wiring.
// Memory side is a req/ack word handshake: requester holds req/addr until ack.
interface icache_if;
    logic [31:0] PCF;
    logic        Invalidate;
    logic [31:0] InstrF;
    logic        MissF;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRData;

    // Cache side
    modport slave (
        input  PCF, Invalidate, MemAck, MemRData,
        output InstrF, MissF, MemReq, MemAddr
    );

    // Fetch stage plus instruction memory side
    modport master (
        output PCF, Invalidate, MemAck, MemRData,
        input  InstrF, MissF, MemReq, MemAddr
    );
endinterface

// File: rtl/icache_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache.
// Read port is combinational (0 cycles); writes land on the next rising edge.
// No backpressure: one write per cycle is always accepted.
module icache_store
    import icache_pkg::*;
#(
    parameter int LINES = 1 << INDEX_BITS,
    parameter int WORDS = 1 << WORD_BITS,
    parameter int TBITS = TAG_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    // combinational read port
    input  logic [$clog2(LINES)-1:0] rd_index,
    input  logic [$clog2(WORDS)-1:0] rd_word,
    output logic                     rd_valid,
    output logic [TBITS-1:0]         rd_tag,
    output logic [31:0]              rd_data,
    // single write port
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic [$clog2(WORDS)-1:0] wr_word,
    input  logic [31:0]              wr_data,
    input  logic                     tag_we,
    input  logic [TBITS-1:0]         wr_tag,
    input  logic                     set_valid,
    // valid maintenance
    input  logic                     clr_index_en,
    input  logic [$clog2(LINES)-1:0] clr_index,
    input  logic                     clr_all
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TBITS-1:0] tag_q  [LINES];
    logic [TBITS-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES][WORDS];
    logic [31:0]      data_d [LINES][WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

    // Next-state of the arrays; a bulk clear overrides any per-line valid update.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            data_d[wr_index][wr_word] = wr_data;
        end
        if (tag_we) begin
            tag_d[wr_index] = wr_tag;
        end
        if (clr_index_en) begin
            valid_d[clr_index] = 1'b0;
        end
        if (set_valid) begin
            valid_d[wr_index] = 1'b1;
        end
        if (clr_all) begin
            valid_d = '0;
        end
    end

    // Valid bits are the only array state that is reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; validity alone guards their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill on miss.
// Hit: InstrF in the same cycle as PCF; miss: MissF for WORDS+1 cycles plus memory waits.
// Memory backpressure: MemReq/MemAddr held until MemAck; fetch stalled via MissF meanwhile.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 1 << INDEX_BITS,
    parameter int WORDS = 1 << WORD_BITS
) (
    input  logic    clk,
    input  logic    reset,
    icache_if.slave bus
);

    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 30 - WB - IB;

    localparam logic [31:0]   LINE_MASK = 32'((WORDS * 4) - 1);
    localparam logic [WB-1:0] BEAT_LAST = WB'(WORDS - 1);

    // FSM and refill bookkeeping
    state_e        state_q, state_d;
    logic [WB-1:0] beat_q, beat_d;
    logic [31:0]   base_q, base_d;
    logic          pend_q, pend_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;

    // Lookup fields of the presented PC
    logic [WB-1:0] pc_word_s;
    logic [IB-1:0] pc_index_s;
    logic [TB-1:0] pc_tag_s;
    logic [31:0]   line_base;

    // Store ports
    logic          rd_valid;
    logic [TB-1:0] rd_tag;
    logic [31:0]   rd_data;
    logic          st_wr_en;
    logic          st_tag_we;
    logic          st_set_valid;
    logic          st_clr_index_en;
    logic [IB-1:0] wr_index;
    logic [TB-1:0] wr_tag;

    // Combinational fetch outputs
    logic          miss_f;
    logic [31:0]   instr_f;

    assign pc_word_s  = WB'(pc_word(bus.PCF, WB));
    assign pc_index_s = IB'(pc_index(bus.PCF, WB, IB));
    assign pc_tag_s   = TB'(pc_tag(bus.PCF, WB, IB));
    assign line_base  = bus.PCF & ~LINE_MASK;

    // Refill writes always target the line latched at miss time, not the live PC.
    assign wr_index = IB'(pc_index(base_q, WB, IB));
    assign wr_tag   = TB'(pc_tag(base_q, WB, IB));

    icache_store #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TBITS (TB)
    ) u_store (
        .clk          (clk),
        .reset        (reset),
        .rd_index     (pc_index_s),
        .rd_word      (pc_word_s),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        (st_wr_en),
        .wr_index     (wr_index),
        .wr_word      (beat_q),
        .wr_data      (bus.MemRData),
        .tag_we       (st_tag_we),
        .wr_tag       (wr_tag),
        .set_valid    (st_set_valid),
        .clr_index_en (st_clr_index_en),
        .clr_index    (pc_index_s),
        .clr_all      (bus.Invalidate)
    );

    // Lookup, miss detection and refill sequencing.
    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        base_d          = base_q;
        pend_d          = pend_q;
        mem_req_d       = mem_req_q;
        mem_addr_d      = mem_addr_q;
        st_wr_en        = 1'b0;
        st_tag_we       = 1'b0;
        st_set_valid    = 1'b0;
        st_clr_index_en = 1'b0;
        miss_f          = 1'b0;
        instr_f         = '0;
        case (state_q)
            IDLE: begin
                if (rd_valid && (rd_tag == pc_tag_s)) begin
                    instr_f = rd_data;
                end else begin
                    // The stale line is dropped now so a reset mid-refill leaves it invalid.
                    miss_f          = 1'b1;
                    base_d          = line_base;
                    beat_d          = '0;
                    st_clr_index_en = 1'b1;
                    mem_req_d       = 1'b1;
                    mem_addr_d      = line_base;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                miss_f = 1'b1;
                if (bus.Invalidate) begin
                    pend_d = 1'b1;
                end
                if (bus.MemAck) begin
                    st_wr_en = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        // An invalidate seen at any point of this refill keeps the line invalid.
                        st_tag_we    = 1'b1;
                        st_set_valid = !pend_q && !bus.Invalidate;
                        pend_d       = 1'b0;
                        mem_req_d    = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        beat_d     = beat_q + WB'(1);
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered FSM state and memory request outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            pend_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            pend_q     <= pend_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.InstrF  = instr_f;
    assign bus.MissF   = miss_f;
    assign bus.MemReq  = mem_req_q;
    assign bus.MemAddr = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, multi-cycle corner sequences,
// and randomized fetches with random memory wait states against a line-level model.
module tb_icache;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    icache_if bus ();

    icache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // memory responder state
    int          ack_mode;   // 0: always ack, 1: every third request cycle, 2: random
    int          wait_cnt;
    logic [31:0] ack_q[$];
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          proto_err;

    typedef struct {
        logic [31:0] pc;
        int          inv;
        int          exp_miss;
        int          exp_acks;
    } vec_t;

    vec_t tbl[14];

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        return (w ^ 32'h5A5A_0000) * 32'h0001_0DCD + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: observe the request side, answer it, advance to the next negedge.
    task automatic tick();
        logic ack;
        #1;
        if (prev_req && !prev_ack) begin
            if (!(bus.MemReq && bus.MemAddr == prev_addr)) proto_err++;
        end
        if (bus.MissF && bus.InstrF != 32'd0) proto_err++;
        ack = 1'b0;
        if (bus.MemReq) begin
            case (ack_mode)
                0: ack = 1'b1;
                1: begin
                    wait_cnt++;
                    if (wait_cnt == 3) begin
                        ack = 1'b1;
                        wait_cnt = 0;
                    end
                end
                default: ack = ($urandom_range(0, 2) != 0);
            endcase
        end
        bus.MemAck   = ack;
        bus.MemRData = ack ? mem_word(bus.MemAddr) : 32'hDEAD_BEEF;
        if (ack) ack_q.push_back(bus.MemAddr);
        prev_req  = bus.MemReq;
        prev_addr = bus.MemAddr;
        prev_ack  = ack;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        bus.PCF        = 32'h0;
        bus.Invalidate = 1'b0;
        bus.MemAck     = 1'b0;
        bus.MemRData   = 32'h0;
        prev_req       = 1'b0;
        prev_ack       = 1'b0;
        prev_addr      = 32'h0;
        tick();
        tick();
        #1;
        chk("rst_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("rst_memaddr", bus.MemAddr, 32'd0);
        chk("rst_missf", {31'd0, bus.MissF}, 32'd1);
        chk("rst_instrf", bus.InstrF, 32'd0);
        reset = 1'b1;
    endtask

    // Present pc until it hits; inv_cycle selects the fetch cycle (0 = first) that pulses Invalidate.
    task automatic do_fetch(input logic [31:0] pc, input int inv_cycle,
                            output int miss_cycles, output logic [31:0] instr,
                            output logic req_at_hit);
        bit done;
        miss_cycles = 0;
        instr       = '0;
        req_at_hit  = 1'b0;
        done        = 1'b0;
        wait_cnt    = 0;
        ack_q.delete();
        bus.PCF = pc;
        for (int c = 0; c < 400 && !done; c++) begin
            bus.Invalidate = (c == inv_cycle);
            #1;
            if (!bus.MissF) begin
                instr      = bus.InstrF;
                req_at_hit = bus.MemReq;
                done       = 1'b1;
            end else begin
                miss_cycles++;
            end
            tick();
        end
        bus.Invalidate = 1'b0;
        chk("fetch_done", {31'd0, done}, 32'd1);
    endtask

    // Every acked address must walk the line of pc in order, once per refill.
    task automatic chk_addr_seq(input string name, input logic [31:0] pc);
        int bad;
        logic [31:0] base;
        bad  = 0;
        base = pc & ~32'(WORDS * 4 - 1);
        foreach (ack_q[k]) begin
            if (ack_q[k] != base + 32'(4 * (k % WORDS))) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        int          mc;
        logic [31:0] ins;
        logic        rq;

        tbl[0]  = '{32'h0000_0100, -1,  5, 4};
        tbl[1]  = '{32'h0000_0104, -1,  0, 0};
        tbl[2]  = '{32'h0000_0108, -1,  0, 0};
        tbl[3]  = '{32'h0000_010C, -1,  0, 0};
        tbl[4]  = '{32'h0000_010B, -1,  0, 0};
        tbl[5]  = '{32'h0000_0500, -1,  5, 4};
        tbl[6]  = '{32'h0000_0100, -1,  5, 4};
        tbl[7]  = '{32'h0000_0504, -1,  5, 4};
        tbl[8]  = '{32'h0000_07FC, -1,  5, 4};
        tbl[9]  = '{32'h0000_07F0, -1,  0, 0};
        tbl[10] = '{32'h0000_0300,  2, 10, 8};
        tbl[11] = '{32'h0000_0304, -1,  0, 0};
        tbl[12] = '{32'h0000_0308,  0,  0, 0};
        tbl[13] = '{32'h0000_0304, -1,  5, 4};

        proto_err = 0;
        ack_mode  = 0;
        @(negedge clk);
        do_reset();

        // Directed table, zero-wait memory
        for (int i = 0; i < 14; i++) begin
            do_fetch(tbl[i].pc, tbl[i].inv, mc, ins, rq);
            chk($sformatf("v%0d_miss_cycles", i), 32'(mc), 32'(tbl[i].exp_miss));
            chk($sformatf("v%0d_instr", i), ins, mem_word(tbl[i].pc));
            chk($sformatf("v%0d_acks", i), 32'(ack_q.size()), 32'(tbl[i].exp_acks));
            chk($sformatf("v%0d_memreq_hit", i), {31'd0, rq}, 32'd0);
            if (tbl[i].exp_acks > 0) chk_addr_seq($sformatf("v%0d_addr_seq", i), tbl[i].pc);
        end
        chk("table_protocol", 32'(proto_err), 32'd0);

        // Wait states: ack every third request cycle
        do_reset();
        ack_mode = 1;
        do_fetch(32'h0000_0100, -1, mc, ins, rq);
        chk("wait_miss_cycles", 32'(mc), 32'd13);
        chk("wait_instr", ins, mem_word(32'h0000_0100));
        chk("wait_acks", 32'(ack_q.size()), 32'd4);
        chk_addr_seq("wait_addr_seq", 32'h0000_0100);
        chk("wait_protocol", 32'(proto_err), 32'd0);
        ack_mode = 0;
        do_fetch(32'h0000_010C, -1, mc, ins, rq);
        chk("wait_hit_after", 32'(mc), 32'd0);
        chk("wait_hit_instr", ins, mem_word(32'h0000_010C));

        // Reset during the third beat of a refill
        do_reset();
        ack_q.delete();
        bus.PCF = 32'h0000_0100;
        tick();
        tick();
        tick();
        chk("midrst_beats_before", 32'(ack_q.size()), 32'd2);
        reset = 1'b0;
        tick();
        #1;
        chk("midrst_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("midrst_missf", {31'd0, bus.MissF}, 32'd1);
        reset = 1'b1;
        do_fetch(32'h0000_0100, -1, mc, ins, rq);
        chk("midrst_refill_cycles", 32'(mc), 32'd5);
        chk("midrst_refill_acks", 32'(ack_q.size()), 32'd4);
        chk_addr_seq("midrst_addr_seq", 32'h0000_0100);
        chk("midrst_instr", ins, mem_word(32'h0000_0100));

        // Randomized fetches with random waits and invalidates against a line-level model
        begin
            logic        m_valid [LINES];
            logic [31:0] m_tag   [LINES];
            logic [31:0] pc;
            int          idx;
            logic [31:0] tg;
            logic        pred_hit;
            int          inv;
            int          exp_acks;

            do_reset();
            ack_mode = 2;
            for (int l = 0; l < LINES; l++) begin
                m_valid[l] = 1'b0;
                m_tag[l]   = '0;
            end
            for (int n = 0; n < 150; n++) begin
                pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
                   | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                idx      = int'((pc >> 4) % LINES);
                tg       = pc >> 8;
                pred_hit = m_valid[idx] && (m_tag[idx] == tg);
                inv      = -1;
                if (pred_hit && $urandom_range(0, 7) == 0) inv = 0;
                else if (!pred_hit && $urandom_range(0, 3) == 0) inv = $urandom_range(1, WORDS);
                exp_acks = pred_hit ? 0 : ((inv > 0) ? 2 * WORDS : WORDS);

                do_fetch(pc, inv, mc, ins, rq);
                chk($sformatf("rnd%0d_first_miss", n), {31'd0, (mc > 0)}, {31'd0, !pred_hit});
                chk($sformatf("rnd%0d_instr", n), ins, mem_word(pc));
                chk($sformatf("rnd%0d_acks", n), 32'(ack_q.size()), 32'(exp_acks));
                if (exp_acks > 0) chk_addr_seq($sformatf("rnd%0d_addr_seq", n), pc);

                if (inv >= 0) begin
                    for (int l = 0; l < LINES; l++) m_valid[l] = 1'b0;
                end
                if (!pred_hit) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                end
            end
            chk("rnd_protocol", 32'(proto_err), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch-stage PC register and a slow instruction memory. It returns `InstrF` combinationally on a hit in the same cycle `PCF` is presented. On a miss it raises `MissF`, which the hazard unit ORs into `StallF`/`StallD`, then refills the whole line from memory through a req/ack word-beat handshake. It replaces the ideal single-cycle instruction memory that feeds the datapath's `InstrF`.

## Interface
- `LINES`, 16: number of lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low (0 = reset), sampled on `clk` rising edge.
- `PCF` in 32: fetch address; bits [1:0] ignored.
- `Invalidate` in 1: one-cycle pulse; clear all valid bits.
- `InstrF` out 32: instruction word; valid when `MissF`=0.
- `MissF` out 1: fetch stall request.
- `MemReq` out 1: word read request to instruction memory.
- `MemAddr` out 32: word-aligned request address.
- `MemAck` in 1: memory returns `MemRData` this cycle.
- `MemRData` in 32: read data, valid only with `MemAck`=1.

## Operation
- Address split:
  - offset = PCF[1:0] (ignored)
  - word = next log2(WORDS) bits
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage per line: valid bit, tag, and WORDS data words.
- Hit = valid[index] & (tag[index] == PCF tag), evaluated combinationally.
- States: IDLE, REFILL.
- IDLE:
  - On a hit: `MissF`=0 and `InstrF`=data[index][word].
  - On a miss: `MissF`=1 and `InstrF`=0. Latch line base = {PCF tag, index, 0s} and beat=0, clear valid[index], and go to REFILL next cycle.
- REFILL:
  - Outputs: `MissF`=1, `InstrF`=0, `MemReq`=1, `MemAddr` = line base + 4·beat.
  - On `MemAck`=1: write `MemRData` into data[latched index][beat].
    - If beat ≠ WORDS−1: increment beat.
    - If beat = WORDS−1: write the tag, set valid unless an invalidate is pending, and return to IDLE.
  - On `MemAck`=0: hold `MemReq`, `MemAddr` and beat unchanged.
- `PCF` changes during REFILL (redirect or branch) are ignored. The refill always completes, and the new PC is looked up in IDLE.
- `Invalidate`:
  - In IDLE: clears all valid bits at the edge. The lookup in that same cycle still uses the pre-clear valid bits.
  - In REFILL: clears all valid bits and sets a pending flag. The refilled line is then left invalid, and the flag clears on return to IDLE.
- `MemAck` in IDLE is ignored.

## Timing
- Reset values: state IDLE, all valid=0, beat=0, pending flag=0, `MemReq`=0, `MemAddr`=0. `MissF` and `InstrF` then follow combinationally (miss on any `PCF` after reset). Data and tag arrays are not reset.
- Reset asserted mid-REFILL: returns to IDLE at that edge and drops `MemReq` the next cycle. The partial line stays invalid.
- Hit latency: 0 cycles (combinational from `PCF`).
- Miss penalty with zero-wait memory (`MemAck` tied 1):
  - Cycle 0: miss detected.
  - Cycles 1..WORDS: beats.
  - Cycle WORDS+1: IDLE hit.
  - `MissF` is high for WORDS+1 cycles in total.
- Each memory wait cycle adds one cycle to the miss penalty.
- `MemReq` never drops between beats of one refill. It drops in the cycle after the last ack.

## Structure
- `icache_pkg`:
  - state enum {IDLE, REFILL}
  - localparam-derived widths: WORD_BITS, INDEX_BITS, TAG_BITS
  - address-field extraction functions
- Sub-module `icache_store`:
  - Holds the valid/tag/data arrays.
  - Combinational read port (index, word).
  - Single write port (index, word, data, tag_we).
  - Bulk valid clear.
- `icache` holds only the FSM, beat counter, line-base register and pending flag.

## Test plan
- Cold miss, LINES=16, WORDS=4, `MemAck`=1: reset, `PCF`=0x100 → `MissF` high 5 cycles; `MemAddr` sequence 0x100, 0x104, 0x108, 0x10C; then `InstrF` = word returned for 0x100.
- Hits after fill: `PCF` 0x104, 0x108, 0x10C on consecutive cycles → `MissF`=0, matching words, `MemReq`=0.
- Conflict eviction: `PCF`=0x500 (same index as 0x100) → refill; then 0x100 misses again.
- Wait states: `MemAck` high every third cycle → `MemAddr` held stable until each ack, `MissF` high 13 cycles, data correct.
- Reset mid-refill: `reset`=0 after beat 2 → next cycle `MemReq`=0; re-fetch of 0x100 performs a full 4-beat refill.
- Invalidate during refill: pulse at beat 1 → refill completes; next fetch of same PC misses again; pulse in IDLE → previously cached 0x104 misses.
